// File: rtl/data_cache.sv
// L1 data cache: 2-way set-associative, 2-word blocks, write-back/write-allocate, LRU.
// Misses and halt-time flushes move whole blocks word-serially over the memory port.
module data_cache #(
    parameter int unsigned SETS  = 8,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned CPUID = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore
);

    localparam int unsigned IDX = $clog2(SETS);
    localparam int unsigned TW  = 29 - IDX;
    localparam int unsigned CPUID_UNUSED = CPUID;

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] WB0  = 4'd1;
    localparam logic [3:0] WB1  = 4'd2;
    localparam logic [3:0] LD0  = 4'd3;
    localparam logic [3:0] LD1  = 4'd4;
    localparam logic [3:0] FCHK = 4'd5;
    localparam logic [3:0] FWB0 = 4'd6;
    localparam logic [3:0] FWB1 = 4'd7;
    localparam logic [3:0] DONE = 4'd8;

    logic [3:0]                    state;
    logic [SETS-1:0][WAYS-1:0]     valid;
    logic [SETS-1:0][WAYS-1:0]     dirty;
    logic [SETS-1:0]               lru;
    logic [TW-1:0]                 tags     [SETS][WAYS];
    logic [31:0]                   blk_data [SETS][WAYS][2];

    logic [TW-1:0]  miss_tag;
    logic [IDX-1:0] miss_idx;
    logic           victim;
    logic [IDX:0]   fptr;

    logic [TW-1:0]  req_tag;
    logic [IDX-1:0] req_idx;
    logic           req_off;
    logic [1:0]     byte_unused;
    logic           req, hit0, hit1, hit, hit_way;
    logic           vict, vict_dirty;
    logic [IDX-1:0] fset, wb_set;
    logic           fway, wb_way, wb_word, ld_word, wb_flush, flast;

    assign req_tag     = dmemaddr[31:3+IDX];
    assign req_idx     = dmemaddr[2+IDX:3];
    assign req_off     = dmemaddr[2];
    assign byte_unused = dmemaddr[1:0];
    assign req         = dmemREN | dmemWEN;

    assign hit0    = valid[req_idx][0] && (tags[req_idx][0] == req_tag);
    assign hit1    = valid[req_idx][1] && (tags[req_idx][1] == req_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    // Invalid ways fill first (way 0 before way 1); only a full set consults LRU.
    assign vict       = !valid[req_idx][0] ? 1'b0 : (!valid[req_idx][1] ? 1'b1 : lru[req_idx]);
    assign vict_dirty = valid[req_idx][vict] && dirty[req_idx][vict];

    // The flush pointer walks {set, way} so the scan order is set-major.
    assign fset  = fptr[IDX:1];
    assign fway  = fptr[0];
    assign flast = (fptr == '1);

    assign wb_flush = (state == FWB0) || (state == FWB1);
    assign wb_set   = wb_flush ? fset : miss_idx;
    assign wb_way   = wb_flush ? fway : victim;
    assign wb_word  = (state == WB1) || (state == FWB1);
    assign ld_word  = (state == LD1);

    assign dhit     = (state == IDLE) && !halt && req && hit;
    assign dmemload = dhit ? blk_data[req_idx][hit_way][req_off] : '0;
    assign flushed  = (state == DONE);

    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = '0;
        dstore = '0;
        case (state)
            WB0, WB1, FWB0, FWB1: begin
                dWEN   = 1'b1;
                daddr  = {tags[wb_set][wb_way], wb_set, wb_word, 2'b00};
                dstore = blk_data[wb_set][wb_way][wb_word];
            end
            LD0, LD1: begin
                dREN  = 1'b1;
                daddr = {miss_tag, miss_idx, ld_word, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            valid    <= '0;
            dirty    <= '0;
            lru      <= '0;
            miss_tag <= '0;
            miss_idx <= '0;
            victim   <= 1'b0;
            fptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        fptr  <= '0;
                        state <= FCHK;
                    end else if (req && hit) begin
                        lru[req_idx] <= ~hit_way;
                        if (dmemWEN) begin
                            blk_data[req_idx][hit_way][req_off] <= dmemstore;
                            dirty[req_idx][hit_way]             <= 1'b1;
                        end
                    end else if (req) begin
                        miss_tag <= req_tag;
                        miss_idx <= req_idx;
                        victim   <= vict;
                        state    <= vict_dirty ? WB0 : LD0;
                    end
                end
                WB0: if (!dwait) state <= WB1;
                WB1: if (!dwait) state <= LD0;
                LD0: if (!dwait) begin
                    blk_data[miss_idx][victim][0] <= dload;
                    state <= LD1;
                end
                LD1: if (!dwait) begin
                    blk_data[miss_idx][victim][1] <= dload;
                    tags[miss_idx][victim]        <= miss_tag;
                    valid[miss_idx][victim]       <= 1'b1;
                    dirty[miss_idx][victim]       <= 1'b0;
                    state <= IDLE;
                end
                FCHK: begin
                    if (valid[fset][fway] && dirty[fset][fway]) state <= FWB0;
                    else if (flast)                              state <= DONE;
                    else                                         fptr  <= fptr + (IDX+1)'(1);
                end
                FWB0: if (!dwait) state <= FWB1;
                FWB1: if (!dwait) begin
                    dirty[fset][fway] <= 1'b0;
                    if (flast) state <= DONE;
                    else begin
                        fptr  <= fptr + (IDX+1)'(1);
                        state <= FCHK;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: word-addressed backing memory, CPU-visible memory view and a
// per-set recency list predict hits, miss latency, evictions and write-back contents.
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        halt = 1'b0;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic [31:0] dmemaddr = '0;
    logic [31:0] dmemstore = '0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic        dwait = 1'b0;
    logic [31:0] dload = '0;

    int total = 0;
    int bad = 0;
    int stall_left = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] bmem  [logic [31:0]];
    logic [31:0] cview [logic [31:0]];
    bit          dirtyblk [logic [31:0]];
    wr_t         wlog [$];
    logic [31:0] rlog [$];
    logic [25:0] t0 [8];
    logic [25:0] t1 [8];
    int          cnt [8];

    logic        prev_wait = 1'b0;
    logic        prev_ren = 1'b0;
    logic        prev_wen = 1'b0;
    logic [31:0] prev_addr = '0;

    data_cache #(.SETS(8), .WAYS(2), .CPUID(0)) dut (
        .CLK(CLK), .RST(RST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dwait(dwait), .dload(dload), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bread(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a ^ 32'hC0DE0000;
    endfunction

    function automatic logic [31:0] cread(input logic [31:0] a);
        if (cview.exists(a)) return cview[a];
        return bread(a);
    endfunction

    // Memory responder and per-cycle compare, all on the falling edge.
    always @(negedge CLK) begin
        if (stall_left > 0 && dREN) begin
            dwait = 1'b1;
            stall_left--;
            dload = 32'hBAD0BAD0;
        end else begin
            dwait = 1'b0;
            dload = dREN ? bread(daddr) : 32'h0;
        end
        if (!RST) begin
            if (prev_wait && (prev_ren || prev_wen)) begin
                check("held_req", {30'b0, dREN, dWEN}, {30'b0, prev_ren, prev_wen});
                check("held_addr", daddr, prev_addr);
            end
            if (dREN || dWEN) check("ren_wen_excl", {31'b0, dREN & dWEN}, 32'd0);
            if (dhit && dmemREN) check("load_data", dmemload, cread(dmemaddr));
            if (dWEN && !dwait) begin
                check("wb_data", dstore, cread(daddr));
                wlog.push_back('{a: daddr, d: dstore});
                bmem[daddr] = dstore;
            end
            if (dREN && !dwait) rlog.push_back(daddr);
            if (dhit && dmemWEN) cview[dmemaddr] = dmemstore;
            if (flushed) check("done_quiet", {29'b0, dhit, dREN, dWEN}, 32'd0);
        end
        prev_wait = dwait;
        prev_ren  = dREN;
        prev_wen  = dWEN;
        prev_addr = daddr;
    end

    task automatic do_reset();
        RST = 1'b1;
        halt = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        dirtyblk.delete();
        cview.delete();
    endtask

    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input int stall, output logic [31:0] got);
        logic [2:0]  si;
        logic [25:0] tg;
        logic [31:0] ev_blk, blk;
        bit          exp_hit, evict_dirty;
        int          cyc, exp_cyc;
        si = a[5:3];
        tg = a[31:6];
        blk = {a[31:3], 3'b000};
        exp_hit = (cnt[si] > 0 && t0[si] == tg) || (cnt[si] > 1 && t1[si] == tg);
        evict_dirty = 1'b0;
        ev_blk = '0;
        if (!exp_hit && cnt[si] == 2) begin
            ev_blk = {t1[si], si, 3'b000};
            evict_dirty = dirtyblk.exists(ev_blk);
        end
        wlog.delete();
        rlog.delete();
        stall_left = stall;
        dmemaddr = a;
        dmemstore = d;
        dmemWEN = we;
        dmemREN = !we;
        cyc = 0;
        @(negedge CLK);
        check("first_cycle_hit", 32'(dhit), 32'(exp_hit));
        while (!dhit && cyc < 100) begin
            cyc++;
            @(negedge CLK);
        end
        got = dmemload;
        exp_cyc = exp_hit ? 0 : ((evict_dirty ? 5 : 3) + stall);
        check("miss_cycles", 32'(cyc), 32'(exp_cyc));
        if (!exp_hit) begin
            check("fill_reads", 32'(rlog.size()), 32'd2);
            if (rlog.size() >= 2) begin
                check("fill_addr0", rlog[0], blk);
                check("fill_addr1", rlog[1], blk + 32'd4);
            end
            check("evict_writes", 32'(wlog.size()), evict_dirty ? 32'd2 : 32'd0);
            if (evict_dirty && wlog.size() >= 2) begin
                check("evict_addr0", wlog[0].a, ev_blk);
                check("evict_addr1", wlog[1].a, ev_blk + 32'd4);
                dirtyblk.delete(ev_blk);
            end
            if (cnt[si] < 2) cnt[si]++;
            t1[si] = t0[si];
            t0[si] = tg;
        end else if (t0[si] != tg) begin
            t1[si] = t0[si];
            t0[si] = tg;
        end
        if (we) dirtyblk[blk] = 1'b1;
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    initial begin
        logic [31:0] v, pa, ca;
        int cyc, ndirty;

        do_reset();
        @(negedge CLK);
        check("rst_dhit", 32'(dhit), 32'd0);
        check("rst_dmemload", dmemload, 32'd0);
        check("rst_flushed", 32'(flushed), 32'd0);
        check("rst_dREN", 32'(dREN), 32'd0);
        check("rst_dWEN", 32'(dWEN), 32'd0);
        check("rst_daddr", daddr, 32'd0);
        check("rst_dstore", dstore, 32'd0);
        @(posedge CLK); #1;

        access(1'b0, 32'h0000_0000, 32'h0, 0, v);
        check("load0_lit", v, 32'hC0DE0000);
        access(1'b1, 32'h0000_00E0, 32'hBEEFDEAD, 0, v);
        access(1'b0, 32'h0000_00E0, 32'h0, 0, v);
        check("loadE0_lit", v, 32'hBEEFDEAD);

        access(1'b1, 32'h0000_00A4, 32'hAAAABBBB, 0, v);
        access(1'b1, 32'h0000_00B8, 32'hC4C4C4C4, 0, v);
        access(1'b1, 32'h0000_0004, 32'hB00B1111, 0, v);
        access(1'b0, 32'h0000_00E0, 32'h0, 0, v);
        check("reloadE0_lit", v, 32'hBEEFDEAD);
        access(1'b0, 32'h0000_00A4, 32'h0, 0, v);
        check("reloadA4_lit", v, 32'hAAAABBBB);
        access(1'b0, 32'h0000_00B8, 32'h0, 0, v);
        check("reloadB8_lit", v, 32'hC4C4C4C4);
        access(1'b0, 32'h0000_0004, 32'h0, 0, v);
        check("reload04_lit", v, 32'hB00B1111);

        access(1'b0, 32'h0000_01E0, 32'h0, 0, v);
        check("load1E0_lit", v, 32'hC0DE01E0);
        check("evict_count_lit", 32'(wlog.size()), 32'd2);
        if (wlog.size() >= 1) begin
            check("evict_first_addr_lit", wlog[0].a, 32'h0000_00E0);
            check("evict_first_data_lit", wlog[0].d, 32'hBEEFDEAD);
        end

        access(1'b0, 32'h0000_0100, 32'h0, 5, v);
        check("stall_load_lit", v, 32'hC0DE0100);

        ndirty = dirtyblk.num();
        wlog.delete();
        halt = 1'b1;
        cyc = 0;
        while (!flushed && cyc < 300) begin
            @(negedge CLK);
            cyc++;
        end
        check("flush_done", 32'(flushed), 32'd1);
        check("flush_writes", 32'(wlog.size()), 32'(2 * ndirty));
        for (int i = 1; i < wlog.size(); i++) begin
            pa = wlog[i-1].a;
            ca = wlog[i].a;
            check("flush_order", 32'(ca[5:3] >= pa[5:3]), 32'd1);
        end
        check("mem_E0_lit", bread(32'h0000_00E0), 32'hBEEFDEAD);
        check("mem_A4_lit", bread(32'h0000_00A4), 32'hAAAABBBB);
        check("mem_B8_lit", bread(32'h0000_00B8), 32'hC4C4C4C4);
        check("mem_04_lit", bread(32'h0000_0004), 32'hB00B1111);
        foreach (cview[k]) check("mem_coherent", bread(k), cview[k]);
        dirtyblk.delete();

        @(posedge CLK); #1;
        dmemaddr = 32'h0000_0004;
        dmemREN = 1'b1;
        repeat (3) @(negedge CLK);
        check("flush_sticky", 32'(flushed), 32'd1);
        @(posedge CLK); #1;

        do_reset();
        @(negedge CLK);
        check("flushed_cleared", 32'(flushed), 32'd0);
        @(posedge CLK); #1;
        dmemaddr = 32'h0000_0040;
        dmemREN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("abort_ren_before", 32'(dREN), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        dmemREN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("abort_ren_after", 32'(dREN), 32'd0);
        check("abort_daddr", daddr, 32'd0);
        @(posedge CLK); #1;

        access(1'b0, 32'h0000_00E0, 32'h0, 0, v);
        check("post_rst_E0_lit", v, 32'hBEEFDEAD);
        access(1'b0, 32'h0000_0040, 32'h0, 0, v);
        check("post_rst_40_lit", v, 32'hC0DE0040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
